// File: rtl/sreg_deser.sv
// Serial-in/parallel-out deserializer: WIDTH bits per frame, LSB- or MSB-first per frame, one-word output holding register.
// Latency: word visible on o_pout/o_pout_valid the cycle after the edge that samples its last bit.
// Backpressure: a frame completing while the holding register is full and not being accepted is dropped and sets sticky o_ovr.
module sreg_deser #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sin,
    input  logic             i_sin_valid,
    input  logic             i_ud,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_pout,
    output logic             o_pout_valid,
    input  logic             i_pout_ready,
    output logic             o_busy,
    output logic             o_ovr,
    input  logic             i_clr_ovr
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [WIDTH-1:0] w_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             w_dir_eff;
    logic             w_done;
    logic [WIDTH-1:0] r_pout;
    logic [WIDTH-1:0] w_pout_nxt;
    logic             r_pout_valid;
    logic             w_pout_valid_nxt;
    logic             r_busy;
    logic             r_ovr;
    logic             w_ovr_nxt;

    // The first bit of a frame uses the live direction input; later bits use the latched copy.
    assign w_dir_eff = (r_state == S_IDLE) ? i_ud : r_dir;
    assign w_shift   = w_dir_eff ? {i_sin, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], i_sin};

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_done      = 1'b0;
        if (i_flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (i_sin_valid) begin
            w_sr_nxt = w_shift;
            case (r_state)
                S_IDLE: begin
                    w_dir_nxt   = i_ud;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_done      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pout_nxt       = r_pout;
        w_pout_valid_nxt = r_pout_valid;
        w_ovr_nxt        = r_ovr;
        if (i_clr_ovr) begin
            w_ovr_nxt = 1'b0;
        end
        if (w_done) begin
            if (!r_pout_valid || i_pout_ready) begin
                w_pout_nxt       = w_shift;
                w_pout_valid_nxt = 1'b1;
            end else begin
                w_ovr_nxt = 1'b1;
            end
        end else if (r_pout_valid && i_pout_ready) begin
            w_pout_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_cnt        <= '0;
            r_dir        <= 1'b0;
            r_pout       <= '0;
            r_pout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_ovr        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sr         <= w_sr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dir        <= w_dir_nxt;
            r_pout       <= w_pout_nxt;
            r_pout_valid <= w_pout_valid_nxt;
            r_busy       <= (w_state_nxt == S_SHIFT);
            r_ovr        <= w_ovr_nxt;
        end
    end

    assign o_pout       = r_pout;
    assign o_pout_valid = r_pout_valid;
    assign o_busy       = r_busy;
    assign o_ovr        = r_ovr;

endmodule

// File: tb/tb_sreg_deser.sv
// Randomized bench for sreg_deser: frame-level reference model built from collected bits, outputs compared every cycle.
module tb_sreg_deser;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         sin_valid;
    logic         ud;
    logic         flush;
    logic         pout_ready;
    logic         clr_ovr;
    logic [W-1:0] pout;
    logic         pout_valid;
    logic         busy;
    logic         ovr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sreg_deser #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sin        (sin),
        .i_sin_valid  (sin_valid),
        .i_ud         (ud),
        .i_flush      (flush),
        .o_pout       (pout),
        .o_pout_valid (pout_valid),
        .i_pout_ready (pout_ready),
        .o_busy       (busy),
        .o_ovr        (ovr),
        .i_clr_ovr    (clr_ovr)
    );

    // Reference state: bits of the frame in flight, plus what the consumer should see.
    int           m_bits[$];
    logic         m_dir;
    logic [W-1:0] m_pout;
    logic         m_vld;
    logic         m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_dir  = 1'b0;
        m_pout = '0;
        m_vld  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // First received bit is weight 1 when LSB-first, weight 2^(W-1) when MSB-first.
    function automatic logic [W-1:0] assemble(input logic dir);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++)
            if (m_bits[i] != 0)
                w = w | (W'(1) << (dir ? i : (W - 1 - i)));
        return w;
    endfunction

    task automatic model_step();
        logic         done;
        logic         over;
        logic [W-1:0] word;
        done = 1'b0;
        over = 1'b0;
        word = '0;
        if (flush) begin
            m_bits.delete();
        end else if (sin_valid) begin
            if (m_bits.size() == 0) m_dir = ud;
            m_bits.push_back(int'(sin));
            if (m_bits.size() == W) begin
                word = assemble(m_dir);
                done = 1'b1;
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_vld || pout_ready) begin
                m_pout = word;
                m_vld  = 1'b1;
            end else begin
                over = 1'b1;
            end
        end else if (m_vld && pout_ready) begin
            m_vld = 1'b0;
        end
        if (over) m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pout"},  32'(pout),       32'(m_pout));
        chk({tag, "_valid"}, 32'(pout_valid), 32'(m_vld));
        chk({tag, "_busy"},  32'(busy),       32'(m_bits.size() != 0));
        chk({tag, "_ovr"},   32'(ovr),        32'(m_ovr));
    endtask

    task automatic cyc(input logic v, input logic s, input logic u, input logic f,
                       input logic r, input logic c, input string tag);
        sin_valid  = v;
        sin        = s;
        ud         = u;
        flush      = f;
        pout_ready = r;
        clr_ovr    = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic u, input bit gaps,
                              input bit toggle_ud, input bit rdy_last, input string tag);
        logic b;
        logic ud_drv;
        for (int i = 0; i < W; i++) begin
            if (gaps)
                while ($urandom_range(0, 2) == 0) cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, tag);
            b      = u ? word[i] : word[W-1-i];
            ud_drv = (toggle_ud && (i % 2 == 1)) ? ~u : u;
            cyc(1'b1, b, ud_drv, 1'b0, rdy_last && (i == W - 1), 1'b0, tag);
        end
    endtask

    task automatic drain();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "drain");
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pout"},  32'(pout),       32'h0);
        chk({tag, "_valid"}, 32'(pout_valid), 32'h0);
        chk({tag, "_busy"},  32'(busy),       32'h0);
        chk({tag, "_ovr"},   32'(ovr),        32'h0);
    endtask

    initial begin
        rst        = 1'b0;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        ud         = 1'b0;
        flush      = 1'b0;
        pout_ready = 1'b0;
        clr_ovr    = 1'b0;
        model_reset();

        // 1: reset held for 3 cycles
        repeat (3) @(negedge clk);
        check_reset_state("rst_hold");
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_rel");
        check_reset_state("rst_after");

        // 2: MSB first
        send_frame(8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, "t2");
        chk("t2_word", 32'(pout), 32'hB2);
        chk("t2_vld",  32'(pout_valid), 32'h1);
        drain();

        // 3: LSB first, ud wiggled mid-frame
        send_frame(8'hB2, 1'b1, 1'b0, 1'b1, 1'b0, "t3");
        chk("t3_word", 32'(pout), 32'hB2);
        drain();

        // 4: gaps inside the frame
        send_frame(8'hB2, 1'($urandom), 1'b1, 1'b0, 1'b0, "t4");
        chk("t4_word", 32'(pout), 32'hB2);
        chk("t4_busy", 32'(busy), 32'h0);
        drain();

        // 5: overrun while consumer stalls, then clear
        send_frame(8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, "t5a");
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, "t5b");
        chk("t5_word", 32'(pout), 32'hB2);
        chk("t5_ovr",  32'(ovr),  32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_clr");
        chk("t5_ovr_clr", 32'(ovr), 32'h0);
        drain();

        // 6: accept on the completion cycle of the second frame
        send_frame(8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, "t6a");
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, "t6b");
        chk("t6_word", 32'(pout), 32'h5A);
        chk("t6_vld",  32'(pout_valid), 32'h1);
        chk("t6_ovr",  32'(ovr), 32'h0);
        drain();

        // 7a: partial frame aborted by flush
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "t7a_part");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t7a_flush");
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, "t7a");
        chk("t7a_word", 32'(pout), 32'h3C);
        drain();

        // 7b: partial frame aborted by reset
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "t7b_part");
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_state("t7b_rst");
        @(negedge clk);
        rst = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, "t7b");
        chk("t7b_word", 32'(pout), 32'h3C);
        drain();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 9) == 0), "rnd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
